// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code counter: direction encodings and a
// width-generic binary-to-Gray helper (operates on up to 32 bits, masked).
package gray_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Reflected-binary conversion; bits at and above 'width' are forced to 0.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin, input int unsigned width);
        logic [31:0] mask;
        mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return (bin ^ (bin >> 1)) & mask;
    endfunction

endpackage

// File: rtl/gray_enc.sv
// Combinational binary -> Gray converter of parameterised width.
module gray_enc
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = 3
) (
    input  logic [WIDTH-1:0] i_bin,
    output logic [WIDTH-1:0] o_gray
);

    assign o_gray = WIDTH'(bin2gray(32'(i_bin), WIDTH));

endmodule

// File: rtl/gray_counter_param.sv
// Parametrised up/down Gray-code counter with synchronous load, sticky
// overflow/underflow flags (with clear) and a registered terminal-count pulse.
// Build option: define GRAY_SATURATE_EN to hold at the end points instead of
// wrapping; flags and Tc still fire on every blocked step.
module gray_counter_param
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH    = 3,
    parameter int unsigned INIT_BIN = 0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic             Up,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadVal,
    input  logic             ClrFlag,
    output logic [WIDTH-1:0] Output,
    output logic             Overflow,
    output logic             Underflow,
    output logic             Tc
);

    localparam logic [WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [WIDTH-1:0] CNT_INIT = INIT_BIN[WIDTH-1:0];

    logic [WIDTH-1:0] r_cnt;
    logic             r_ovf;
    logic             r_unf;
    logic             r_tc;

    logic [WIDTH-1:0] w_cnt_nxt;
    logic             w_set_ovf;
    logic             w_set_unf;

    // Next-count mux: load beats count; end-point steps raise the event flags.
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_set_ovf = 1'b0;
        w_set_unf = 1'b0;
        if (Load) begin
            w_cnt_nxt = LoadVal;
        end else if (En) begin
            if (Up == DIR_UP) begin
                if (r_cnt == CNT_MAX) begin
                    w_set_ovf = 1'b1;
`ifdef GRAY_SATURATE_EN
                    w_cnt_nxt = r_cnt;
`else
                    w_cnt_nxt = '0;
`endif
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end else begin
                if (r_cnt == '0) begin
                    w_set_unf = 1'b1;
`ifdef GRAY_SATURATE_EN
                    w_cnt_nxt = r_cnt;
`else
                    w_cnt_nxt = CNT_MAX;
`endif
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
        end
    end

    // Count, sticky flags (a new event beats ClrFlag) and one-cycle Tc.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_cnt <= CNT_INIT;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
            r_tc  <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_ovf <= w_set_ovf | (r_ovf & ~ClrFlag);
            r_unf <= w_set_unf | (r_unf & ~ClrFlag);
            r_tc  <= w_set_ovf | w_set_unf;
        end
    end

    gray_enc #(
        .WIDTH (WIDTH)
    ) u_enc (
        .i_bin  (r_cnt),
        .o_gray (Output)
    );

    assign Overflow  = r_ovf;
    assign Underflow = r_unf;
    assign Tc        = r_tc;

endmodule

// File: tb/tb_gray_counter_param.sv
// Directed self-checking bench for gray_counter_param (WIDTH=3, INIT_BIN=0).
// The saturation scenario only runs when GRAY_SATURATE_EN is defined.
module tb_gray_counter_param;

    logic       Clk;
    logic       Reset;
    logic       En;
    logic       Up;
    logic       Load;
    logic [2:0] LoadVal;
    logic       ClrFlag;
    logic [2:0] Output;
    logic       Overflow;
    logic       Underflow;
    logic       Tc;

    int unsigned n_checks;
    int unsigned n_errors;

    gray_counter_param #(
        .WIDTH    (3),
        .INIT_BIN (0)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .En        (En),
        .Up        (Up),
        .Load      (Load),
        .LoadVal   (LoadVal),
        .ClrFlag   (ClrFlag),
        .Output    (Output),
        .Overflow  (Overflow),
        .Underflow (Underflow),
        .Tc        (Tc)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; En = 1'b0; Up = 1'b1; Load = 1'b0; LoadVal = 3'd0; ClrFlag = 1'b0;
        #3;
        n_checks++;
        if ({Output, Overflow, Underflow, Tc} !== 6'b000_000) begin
            n_errors++;
            $display("FAIL reset_state: got out=%b ovf=%b unf=%b tc=%b, want 000 0 0 0", Output, Overflow, Underflow, Tc);
        end
        step();
        Reset = 1'b0;
        n_checks++;
        if (Output !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_hold: got out=%b, want 000", Output);
        end
    endtask

    task automatic test_count_up();
        logic [2:0] exp_seq [8] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
        En = 1'b1; Up = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            n_checks++;
            if (Output !== exp_seq[i] || Tc !== (i == 7) || Overflow !== (i == 7) || Underflow !== 1'b0) begin
                n_errors++;
                $display("FAIL count_up[%0d]: got out=%b tc=%b ovf=%b unf=%b, want out=%b tc=%b ovf=%b unf=0",
                         i, Output, Tc, Overflow, Underflow, exp_seq[i], (i == 7), (i == 7));
            end
        end
        En = 1'b0;
    endtask

    task automatic test_clrflag();
        step();
        n_checks++;
        if (Overflow !== 1'b1 || Tc !== 1'b0 || Output !== 3'b000) begin
            n_errors++;
            $display("FAIL idle_hold: got ovf=%b tc=%b out=%b, want ovf=1 tc=0 out=000", Overflow, Tc, Output);
        end
        ClrFlag = 1'b1;
        step();
        ClrFlag = 1'b0;
        n_checks++;
        if (Overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL clrflag: got ovf=%b, want 0", Overflow);
        end
        Load = 1'b1; LoadVal = 3'd7;
        step();
        Load = 1'b0;
        En = 1'b1; Up = 1'b1; ClrFlag = 1'b1;
        step();
        En = 1'b0; ClrFlag = 1'b0;
        n_checks++;
        if (Overflow !== 1'b1 || Tc !== 1'b1 || Output !== 3'b000) begin
            n_errors++;
            $display("FAIL clr_vs_wrap: got ovf=%b tc=%b out=%b, want ovf=1 tc=1 out=000", Overflow, Tc, Output);
        end
    endtask

    task automatic test_count_down();
        En = 1'b1; Up = 1'b0;
        step();
        En = 1'b0;
        n_checks++;
        if (Output !== 3'b100 || Underflow !== 1'b1 || Tc !== 1'b1 || Overflow !== 1'b1) begin
            n_errors++;
            $display("FAIL down_wrap: got out=%b unf=%b tc=%b ovf=%b, want out=100 unf=1 tc=1 ovf=1",
                     Output, Underflow, Tc, Overflow);
        end
        step();
        n_checks++;
        if (Tc !== 1'b0) begin
            n_errors++;
            $display("FAIL tc_pulse_end: got tc=%b, want 0", Tc);
        end
        Load = 1'b1; LoadVal = 3'd0;
        step();
        Load = 1'b0;
        En = 1'b1; Up = 1'b0; ClrFlag = 1'b1;
        step();
        En = 1'b0; ClrFlag = 1'b0;
        n_checks++;
        if (Underflow !== 1'b1 || Overflow !== 1'b0 || Output !== 3'b100 || Tc !== 1'b1) begin
            n_errors++;
            $display("FAIL clr_other_flag: got unf=%b ovf=%b out=%b tc=%b, want unf=1 ovf=0 out=100 tc=1",
                     Underflow, Overflow, Output, Tc);
        end
    endtask

    task automatic test_load();
        Load = 1'b1; LoadVal = 3'd5; En = 1'b1; Up = 1'b1;
        step();
        Load = 1'b0;
        n_checks++;
        if (Output !== 3'b111 || Tc !== 1'b0 || Overflow !== 1'b0 || Underflow !== 1'b1) begin
            n_errors++;
            $display("FAIL load: got out=%b tc=%b ovf=%b unf=%b, want out=111 tc=0 ovf=0 unf=1",
                     Output, Tc, Overflow, Underflow);
        end
        step();
        n_checks++;
        if (Output !== 3'b101) begin
            n_errors++;
            $display("FAIL load_then_inc: got out=%b, want 101", Output);
        end
        Load = 1'b1; LoadVal = 3'd0; En = 1'b1; Up = 1'b0;
        step();
        Load = 1'b0; En = 1'b0;
        n_checks++;
        if (Output !== 3'b000 || Tc !== 1'b0) begin
            n_errors++;
            $display("FAIL load_at_zero_down: got out=%b tc=%b, want out=000 tc=0", Output, Tc);
        end
    endtask

    task automatic test_dir_toggle();
        En = 1'b1; Up = 1'b1;
        step();
        step();
        Up = 1'b0;
        step();
        En = 1'b0;
        n_checks++;
        if (Output !== 3'b001 || Tc !== 1'b0) begin
            n_errors++;
            $display("FAIL dir_toggle: got out=%b tc=%b, want out=001 tc=0", Output, Tc);
        end
    endtask

    task automatic test_async_reset();
        Load = 1'b1; LoadVal = 3'd4;
        step();
        Load = 1'b0;
        n_checks++;
        if (Output !== 3'b110) begin
            n_errors++;
            $display("FAIL preload_4: got out=%b, want 110", Output);
        end
        En = 1'b1; Up = 1'b1;
        #2;
        Reset = 1'b1;
        #1;
        n_checks++;
        if (Output !== 3'b000 || Overflow !== 1'b0 || Underflow !== 1'b0 || Tc !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset: got out=%b ovf=%b unf=%b tc=%b, want 000 0 0 0",
                     Output, Overflow, Underflow, Tc);
        end
        #1;
        Reset = 1'b0;
        step();
        n_checks++;
        if (Output !== 3'b001) begin
            n_errors++;
            $display("FAIL after_reset_count: got out=%b, want 001", Output);
        end
        En = 1'b0;
    endtask

`ifdef GRAY_SATURATE_EN
    task automatic test_saturate();
        Load = 1'b1; LoadVal = 3'd7;
        step();
        Load = 1'b0;
        En = 1'b1; Up = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (Output !== 3'b100 || Overflow !== 1'b1 || Tc !== 1'b1) begin
                n_errors++;
                $display("FAIL sat_up[%0d]: got out=%b ovf=%b tc=%b, want out=100 ovf=1 tc=1", i, Output, Overflow, Tc);
            end
        end
        Load = 1'b1; LoadVal = 3'd0;
        step();
        Load = 1'b0; Up = 1'b0;
        step();
        En = 1'b0;
        n_checks++;
        if (Output !== 3'b000 || Underflow !== 1'b1 || Tc !== 1'b1) begin
            n_errors++;
            $display("FAIL sat_down: got out=%b unf=%b tc=%b, want out=000 unf=1 tc=1", Output, Underflow, Tc);
        end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_count_up();
        test_clrflag();
        test_count_down();
        test_load();
        test_dir_toggle();
        test_async_reset();
`ifdef GRAY_SATURATE_EN
        test_saturate();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
